// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus APB bus signals of the APB requester bridge.
// The master modport is the bridge's view; the slave modport is the requester/completer side.
interface apb_master_bridge_if #(
   parameter int unsigned AMBA_WORD       = 32,
   parameter int unsigned AMBA_ADDR_WIDTH = 20
);
   logic                       cmd_valid;
   logic                       cmd_ready;
   logic                       cmd_write;
   logic [AMBA_ADDR_WIDTH-1:0] cmd_addr;
   logic [AMBA_WORD-1:0]       cmd_wdata;
   logic                       rsp_valid;
   logic [AMBA_WORD-1:0]       rsp_rdata;
   logic                       rsp_err;
   logic                       PSEL;
   logic                       PENABLE;
   logic [AMBA_ADDR_WIDTH-1:0] PADDR;
   logic                       PWRITE;
   logic [AMBA_WORD-1:0]       PWDATA;
   logic [AMBA_WORD-1:0]       PRDATA;
   logic                       PREADY;
   logic                       PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PADDR, PWRITE, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PADDR, PWRITE, PWDATA
   );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: single-outstanding command/response turned into SETUP/ACCESS transfers,
// with PREADY wait states, PSLVERR reporting and an optional wait-state timeout.
module apb_master_bridge #(
   parameter int unsigned AMBA_WORD       = 32,
   parameter int unsigned AMBA_ADDR_WIDTH = 20,
   parameter int unsigned TIMEOUT_CYCLES  = 16
) (
   input logic                clk,
   input logic                rst,
   apb_master_bridge_if.master bus
);
   localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast =
      CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

   state_e                     state_q, state_d;
   logic                       cmd_ready_q, cmd_ready_d;
   logic                       psel_q, psel_d;
   logic                       penable_q, penable_d;
   logic [AMBA_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic                       pwrite_q, pwrite_d;
   logic [AMBA_WORD-1:0]       pwdata_q, pwdata_d;
   logic                       rsp_valid_q, rsp_valid_d;
   logic [AMBA_WORD-1:0]       rsp_rdata_q, rsp_rdata_d;
   logic                       rsp_err_q, rsp_err_d;
   logic [CntW-1:0]            cnt_q, cnt_d;

   always_comb begin
      state_d     = state_q;
      cmd_ready_d = cmd_ready_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      paddr_d     = paddr_q;
      pwrite_d    = pwrite_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b0;
      cnt_d       = cnt_q;
      unique case (state_q)
         StIdle: begin
            cmd_ready_d = 1'b1;
            if (bus.cmd_valid && cmd_ready_q) begin
               state_d     = StSetup;
               cmd_ready_d = 1'b0;
               psel_d      = 1'b1;
               penable_d   = 1'b0;
               paddr_d     = bus.cmd_addr;
               pwrite_d    = bus.cmd_write;
               pwdata_d    = bus.cmd_wdata;
               cnt_d       = '0;
            end
         end
         StSetup: begin
            state_d   = StAccess;
            penable_d = 1'b1;
         end
         StAccess: begin
            if (bus.PREADY) begin
               rsp_valid_d = 1'b1;
               rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
               rsp_err_d   = bus.PSLVERR;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
               // This wait cycle is the TIMEOUT_CYCLES-th one: give up on the completer.
               if (TIMEOUT_CYCLES != 0 && cnt_q == CntLast) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  psel_d      = 1'b0;
                  penable_d   = 1'b0;
                  cmd_ready_d = 1'b1;
                  state_d     = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         cmd_ready_q <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         paddr_q     <= paddr_d;
         pwrite_q    <= pwrite_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.PSEL      = psel_q;
   assign bus.PENABLE   = penable_q;
   assign bus.PADDR     = paddr_q;
   assign bus.PWRITE    = pwrite_q;
   assign bus.PWDATA    = pwdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
endmodule
